lcd_pattern_gen: RTL and testbench
==================================

LCD_PATTERN_GEN -- requirements
Module: lcd_pattern_gen

Interface
REQ-001 SHALL have parameter WidthPixel, default 480, meaning active pixels per line.
REQ-002 SHALL have parameter HightPixel, default 272, meaning active lines per frame.
REQ-003 SHALL have parameter BarWidth, default 60, meaning pixels per colour bar.
REQ-004 SHALL have parameter BoxSize, default 32, meaning moving-box edge length in pixels.
REQ-005 SHALL have port PixelClk, input, 1 bit: sole clock, all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: synchronous reset, active-high.
REQ-007 SHALL have ports DE_in, HSYNC_in, VSYNC_in, each input, 1 bit: timing from the upstream timing generator; syncs are active-low.
REQ-008 SHALL have port Mode, input, 2 bits: pattern select.
REQ-009 SHALL have ports LCD_DE, LCD_HSYNC, LCD_VSYNC, each output, 1 bit: timing delayed to align with pixel data.
REQ-010 SHALL have ports LCD_R, LCD_G, LCD_B, outputs of 5, 6 and 5 bits: RGB565 pixel data.

Function
REQ-011 SHALL delay DE_in, HSYNC_in and VSYNC_in by exactly 2 PixelClk cycles to LCD_DE, LCD_HSYNC and LCD_VSYNC.
REQ-012 SHALL present the pixel for an input DE_in cycle on LCD_R/G/B 2 cycles later; RGB SHALL be 0 whenever LCD_DE=0.
REQ-013 SHALL keep x counter: increment on each DE_in=1 cycle, clear on the cycle after DE_in falls, saturate at WidthPixel-1.
REQ-014 SHALL keep y counter: increment on each DE_in falling edge, clear on VSYNC_in falling edge, saturate at HightPixel-1.
REQ-015 SHALL keep bar index (3 bits) plus sub-counter counting to BarWidth-1; no divider; clear together with x; index saturates at 7.
REQ-016 SHALL sample Mode only on VSYNC_in falling edge (frame start); mid-frame Mode changes SHALL take effect next frame.
REQ-017 Mode 0, colour bars, index 0..7: white, yellow, cyan, green, magenta, red, blue, black; full-scale components (R=31, G=63, B=31).
REQ-018 Mode 1, checkerboard: white when x[4] XOR y[4] = 1, else black.
REQ-019 Mode 2, gradient: R=x[8:4], G=y[8:3], B=31-x[8:4], each truncated to field width.
REQ-020 Mode 3, moving box: white where box_x<=x<box_x+BoxSize and box_y<=y<box_y+BoxSize; elsewhere blue (B=31).
REQ-021 SHALL update box position once per frame on VSYNC_in falling edge by ±1 per axis according to direction bits dx, dy.
REQ-022 SHALL invert dx and step the opposite way when box_x would exceed WidthPixel-BoxSize or fall below 0; same for dy with HightPixel.
REQ-023 SHALL treat a corner hit (both axes at limit in the same frame) as two independent inversions in that frame.
REQ-024 SHALL advance the box in every mode, so the position is continuous when entering Mode 3.
REQ-025 SHALL keep x and y counters and syncs consistent if DE_in and a VSYNC_in falling edge coincide: y clears, then x counts from 0.

Reset
REQ-026 SHALL, while RST=1, force LCD_DE=0, LCD_HSYNC=1, LCD_VSYNC=1 and LCD_R/G/B=0.
REQ-027 SHALL, while RST=1, clear x, y, bar counters, box_x, box_y and latched mode; set dx=dy=+1.
REQ-028 SHALL produce valid output from the second cycle after RST deasserts, given valid inputs; reset mid-frame SHALL restart cleanly at the next VSYNC_in edge.

Structure
REQ-029 SHALL place the RGB565 bar colour table and Mode encodings in a shared package used by the timing generator and this block.
REQ-030 SHALL implement box position and bounce logic in one sub-module, lcd_box_mover.

Verification
REQ-031 Reset: RST=1 for 3 cycles with DE_in=1 -> LCD_DE=0, syncs=1, RGB=0 throughout.
REQ-032 Mode 0, one 480-pixel line -> pixel 0 RGB=(31,63,31); pixel 60 (31,63,0); pixel 420 (0,0,0); LCD_DE delayed exactly 2 cycles.
REQ-033 Mode 1 -> pixel (16,0) white, (16,16) black, (0,0) black.
REQ-034 Mode 2 -> pixel (479,271) RGB=(29,33,2); pixel (0,0) RGB=(0,0,31).
REQ-035 Mode 3 after 448 frames from reset -> box_x=448, dx inverts; frame 449 box_x=447; box_y bounces at 240.
REQ-036 Mode toggled 0->2 at line 100 -> frame stays bars until next VSYNC_in falling edge, then gradient.

Source files
------------

// File: rtl/lcd_pattern_gen_pkg.sv
// Shared definitions for the LCD test-pattern path: pattern mode encodings,
// RGB565 pixel type and the colour-bar table.
package lcd_pattern_gen_pkg;

  // Counter width; wide enough for panels up to 4095 pixels/lines and for
  // the fixed x[8:4] / y[8:3] gradient slices.
  localparam int CW = 12;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_BOX      = 2'd3
  } mode_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // One pipeline stage: timing plus the pixel that goes with it.
  typedef struct packed {
    logic    de;
    logic    hs;
    logic    vs;
    rgb565_t rgb;
  } pix_pipe_t;

  localparam rgb565_t RGB_BLACK = '{r: 5'd0,  g: 6'd0,  b: 5'd0};
  localparam rgb565_t RGB_WHITE = '{r: 5'd31, g: 6'd63, b: 5'd31};
  localparam rgb565_t RGB_BLUE  = '{r: 5'd0,  g: 6'd0,  b: 5'd31};

  // Blank timing: syncs are active-low, so idle is high.
  localparam pix_pipe_t PIPE_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: RGB_BLACK};

  // Standard 8-bar order, full-scale components.
  function automatic rgb565_t bar_colour(input logic [2:0] idx);
    rgb565_t c;
    c = RGB_BLACK;
    case (idx)
      3'd0: c = RGB_WHITE;
      3'd1: c = '{r: 5'd31, g: 6'd63, b: 5'd0};   // yellow
      3'd2: c = '{r: 5'd0,  g: 6'd63, b: 5'd31};  // cyan
      3'd3: c = '{r: 5'd0,  g: 6'd63, b: 5'd0};   // green
      3'd4: c = '{r: 5'd31, g: 6'd0,  b: 5'd31};  // magenta
      3'd5: c = '{r: 5'd31, g: 6'd0,  b: 5'd0};   // red
      3'd6: c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_box_mover.sv
// Bouncing-box position: one step per frame on each axis, reversing
// direction at the panel edges so the box always stays fully on screen.
module lcd_box_mover
  import lcd_pattern_gen_pkg::*;
#(
  parameter int WidthPixel = 480,
  parameter int HightPixel = 272,
  parameter int BoxSize    = 32
) (
  input  logic          PixelClk,
  input  logic          RST,
  input  logic          step,
  output logic [CW-1:0] box_x,
  output logic [CW-1:0] box_y
);

  localparam logic [CW-1:0] X_LIM = CW'(WidthPixel - BoxSize);
  localparam logic [CW-1:0] Y_LIM = CW'(HightPixel - BoxSize);

  // direction bits: 1 = moving towards larger coordinates
  logic dx, dy;

  // Axes are independent, so a corner hit simply flips both in one frame.
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      box_x <= '0;
      box_y <= '0;
      dx    <= 1'b1;
      dy    <= 1'b1;
    end else if (step) begin
      if (dx) begin
        if (box_x >= X_LIM) begin
          dx    <= 1'b0;
          box_x <= box_x - 1'b1;
        end else begin
          box_x <= box_x + 1'b1;
        end
      end else begin
        if (box_x == '0) begin
          dx    <= 1'b1;
          box_x <= box_x + 1'b1;
        end else begin
          box_x <= box_x - 1'b1;
        end
      end

      if (dy) begin
        if (box_y >= Y_LIM) begin
          dy    <= 1'b0;
          box_y <= box_y - 1'b1;
        end else begin
          box_y <= box_y + 1'b1;
        end
      end else begin
        if (box_y == '0) begin
          dy    <= 1'b1;
          box_y <= box_y + 1'b1;
        end else begin
          box_y <= box_y - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern generator. Tracks the pixel position from upstream
// DE/VSYNC, colours it according to the frame's mode, and re-aligns timing
// with the pixel through a two-stage pipeline.
module lcd_pattern_gen
  import lcd_pattern_gen_pkg::*;
#(
  parameter int WidthPixel = 480,
  parameter int HightPixel = 272,
  parameter int BarWidth   = 60,
  parameter int BoxSize    = 32
) (
  input  logic       PixelClk,
  input  logic       RST,
  input  logic       DE_in,
  input  logic       HSYNC_in,
  input  logic       VSYNC_in,
  input  logic [1:0] Mode,
  output logic       LCD_DE,
  output logic       LCD_HSYNC,
  output logic       LCD_VSYNC,
  output logic [4:0] LCD_R,
  output logic [5:0] LCD_G,
  output logic [4:0] LCD_B
);

  localparam int STAGES = 2;
  localparam logic [CW-1:0] X_MAX   = CW'(WidthPixel - 1);
  localparam logic [CW-1:0] Y_MAX   = CW'(HightPixel - 1);
  localparam logic [CW-1:0] BAR_MAX = CW'(BarWidth - 1);
  localparam logic [CW-1:0] BOX_SZ  = CW'(BoxSize);

  logic          de_prev, vs_prev;
  logic          de_fall, vs_fall;
  logic [CW-1:0] x, y, y_cur;
  logic [CW-1:0] bar_sub;
  logic [2:0]    bar_idx;
  logic [CW-1:0] box_x, box_y;
  mode_e         mode_q, mode_cur;
  logic          in_box;
  rgb565_t       pix;
  pix_pipe_t [STAGES:1] pipe;

  assign de_fall = de_prev & ~DE_in;
  assign vs_fall = vs_prev & ~VSYNC_in;

  // At frame start the new mode and y=0 already apply to this cycle's pixel,
  // so a DE coinciding with the VSYNC edge lands on line 0 of the new frame.
  assign mode_cur = vs_fall ? mode_e'(Mode) : mode_q;
  assign y_cur    = vs_fall ? '0 : y;

  // Edge detectors; idle values match blank timing.
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      de_prev <= 1'b0;
      vs_prev <= 1'b1;
    end else begin
      de_prev <= DE_in;
      vs_prev <= VSYNC_in;
    end
  end

  // Horizontal position: counts active pixels, held at 0 through blanking.
  always_ff @(posedge PixelClk) begin
    if (RST || !DE_in) x <= '0;
    else if (x < X_MAX) x <= x + 1'b1;
  end

  // Vertical position: advances at the end of each active line.
  always_ff @(posedge PixelClk) begin
    if (RST || vs_fall) y <= '0;
    else if (de_fall && y < Y_MAX) y <= y + 1'b1;
  end

  // Bar index tracked with a sub-counter instead of dividing x by BarWidth.
  always_ff @(posedge PixelClk) begin
    if (RST || !DE_in) begin
      bar_idx <= '0;
      bar_sub <= '0;
    end else if (bar_sub == BAR_MAX) begin
      bar_sub <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_sub <= bar_sub + 1'b1;
    end
  end

  // Mode is frozen for a whole frame to avoid tearing mid-picture.
  always_ff @(posedge PixelClk) begin
    if (RST) mode_q <= MODE_BARS;
    else if (vs_fall) mode_q <= mode_e'(Mode);
  end

  // The box keeps moving in every mode so entering box mode is seamless.
  lcd_box_mover #(
    .WidthPixel(WidthPixel),
    .HightPixel(HightPixel),
    .BoxSize   (BoxSize)
  ) u_box (
    .PixelClk(PixelClk),
    .RST     (RST),
    .step    (vs_fall),
    .box_x   (box_x),
    .box_y   (box_y)
  );

  assign in_box = (x >= box_x) && (x < box_x + BOX_SZ) &&
                  (y_cur >= box_y) && (y_cur < box_y + BOX_SZ);

  // Pixel colour for the current position.
  always_comb begin
    pix = RGB_BLACK;
    case (mode_cur)
      MODE_BARS:     pix = bar_colour(bar_idx);
      MODE_CHECKER:  pix = (x[4] ^ y_cur[4]) ? RGB_WHITE : RGB_BLACK;
      MODE_GRADIENT: pix = '{r: x[8:4], g: y_cur[8:3], b: 5'd31 - x[8:4]};
      MODE_BOX:      pix = in_box ? RGB_WHITE : RGB_BLUE;
      default:       pix = RGB_BLACK;
    endcase
  end

  // Timing/pixel pipeline; RGB is blanked outside DE at entry.
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      for (int i = 1; i <= STAGES; i++) pipe[i] <= PIPE_IDLE;
    end else begin
      pipe[1] <= '{de: DE_in, hs: HSYNC_in, vs: VSYNC_in,
                   rgb: (DE_in ? pix : RGB_BLACK)};
      for (int i = 2; i <= STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign LCD_DE    = pipe[STAGES].de;
  assign LCD_HSYNC = pipe[STAGES].hs;
  assign LCD_VSYNC = pipe[STAGES].vs;
  assign LCD_R     = pipe[STAGES].rgb.r;
  assign LCD_G     = pipe[STAGES].rgb.g;
  assign LCD_B     = pipe[STAGES].rgb.b;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen: every driven cycle pushes the expected output
// tuple to a queue; it is popped and compared two cycles later.
module tb_lcd_pattern_gen;

  localparam int WidthPixel = 480;
  localparam int HightPixel = 272;
  localparam int BarWidth   = 60;
  localparam int BoxSize    = 32;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } obs_t;

  localparam obs_t RST_VAL = '{de: 1'b0, hs: 1'b1, vs: 1'b1, r: 5'd0, g: 6'd0, b: 5'd0};

  logic       PixelClk = 1'b0;
  logic       RST, DE_in, HSYNC_in, VSYNC_in;
  logic [1:0] Mode;
  logic       LCD_DE, LCD_HSYNC, LCD_VSYNC;
  logic [4:0] LCD_R, LCD_B;
  logic [5:0] LCD_G;

  lcd_pattern_gen #(
    .WidthPixel(WidthPixel), .HightPixel(HightPixel),
    .BarWidth(BarWidth), .BoxSize(BoxSize)
  ) dut (
    .PixelClk(PixelClk), .RST(RST), .DE_in(DE_in), .HSYNC_in(HSYNC_in),
    .VSYNC_in(VSYNC_in), .Mode(Mode), .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC),
    .LCD_VSYNC(LCD_VSYNC), .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B)
  );

  always #5 PixelClk = ~PixelClk;

  int n_chk = 0;
  int n_pass = 0;
  obs_t  sbq[$];
  string tq[$];
  string tag;

  // bench model state
  int ex, ey, m_lat, bx, by, nframes;
  bit bdx, bdy, prev_de, prev_vs;
  logic [15:0] bar_tbl [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic chk(input string t, input obs_t got, input obs_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got de%0b hs%0b vs%0b rgb(%0d,%0d,%0d) want de%0b hs%0b vs%0b rgb(%0d,%0d,%0d)",
                  t, got.de, got.hs, got.vs, got.r, got.g, got.b,
                  want.de, want.hs, want.vs, want.r, want.g, want.b);
  endtask

  task automatic model_reset();
    ex = 0; ey = 0; m_lat = 0; bx = 0; by = 0; bdx = 1; bdy = 1;
    prev_de = 0; prev_vs = 1; nframes = 0;
  endtask

  task automatic box_step();
    if (bdx) begin
      if (bx + 1 > WidthPixel - BoxSize) begin bdx = 0; bx = bx - 1; end
      else bx = bx + 1;
    end else begin
      if (bx - 1 < 0) begin bdx = 1; bx = bx + 1; end
      else bx = bx - 1;
    end
    if (bdy) begin
      if (by + 1 > HightPixel - BoxSize) begin bdy = 0; by = by - 1; end
      else by = by + 1;
    end else begin
      if (by - 1 < 0) begin bdy = 1; by = by + 1; end
      else by = by - 1;
    end
  endtask

  function automatic obs_t model_pix(input int px, input int py);
    obs_t o;
    int idx;
    o = '0;
    o.de = 1'b1;
    case (m_lat)
      0: begin
        idx = px / BarWidth;
        if (idx > 7) idx = 7;
        {o.r, o.g, o.b} = bar_tbl[idx];
      end
      1: if ((((px >> 4) ^ (py >> 4)) & 1) == 1) {o.r, o.g, o.b} = 16'hFFFF;
      2: begin
        o.r = 5'(px >> 4);
        o.g = 6'(py >> 3);
        o.b = 5'(31 - (px >> 4));
      end
      default: begin
        if (px >= bx && px < bx + BoxSize && py >= by && py < by + BoxSize)
          {o.r, o.g, o.b} = 16'hFFFF;
        else
          {o.r, o.g, o.b} = 16'h001F;
      end
    endcase
    return o;
  endfunction

  // Drive one cycle, record what should appear two cycles later, then
  // compare the output that is due now.
  task automatic tick(input logic de, input logic hs, input logic vs);
    obs_t e, got, want;
    string t;
    bit vfall;
    DE_in = de; HSYNC_in = hs; VSYNC_in = vs;
    if (RST) begin
      e = RST_VAL;
      model_reset();
    end else begin
      vfall = prev_vs && !vs;
      if (vfall) begin
        m_lat = int'(Mode);
        box_step();
        ey = 0;
        nframes++;
      end
      e = '0;
      if (de) begin
        e = model_pix(ex, ey);
        if (ex < WidthPixel - 1) ex++;
      end else begin
        if (prev_de && !vfall && ey < HightPixel - 1) ey++;
        ex = 0;
      end
      e.hs = hs;
      e.vs = vs;
      prev_de = de;
      prev_vs = vs;
    end
    sbq.push_back(e);
    tq.push_back(tag);
    @(posedge PixelClk);
    #1;
    if (sbq.size() >= 2) begin
      want = sbq.pop_front();
      t = tq.pop_front();
      got = '{de: LCD_DE, hs: LCD_HSYNC, vs: LCD_VSYNC, r: LCD_R, g: LCD_G, b: LCD_B};
      chk(t, got, want);
    end
  endtask

  task automatic frame_start();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
  endtask

  task automatic line(input int n);
    repeat (n) tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    RST = 1'b1; DE_in = 1'b1; HSYNC_in = 1'b1; VSYNC_in = 1'b1; Mode = 2'd0;
    model_reset();
    // entry for the first output sample, taken after the first reset edge
    tag = "rst";
    sbq.push_back(RST_VAL);
    tq.push_back(tag);
    repeat (3) tick(1'b1, 1'b1, 1'b1);

    RST = 1'b0;
    tag = "idle";
    repeat (2) tick(1'b0, 1'b1, 1'b1);

    tag = "bars";
    Mode = 2'd0;
    frame_start();
    line(480);

    tag = "checker";
    Mode = 2'd1;
    frame_start();
    repeat (17) line(20);

    tag = "gradient";
    Mode = 2'd2;
    frame_start();
    line(480);
    repeat (270) line(1);
    line(480);

    tag = "toggle";
    Mode = 2'd0;
    frame_start();
    for (int l = 0; l < 101; l++) begin
      if (l == 100) Mode = 2'd2;
      line(64);
    end
    tag = "toggle_next";
    frame_start();
    line(480);

    tag = "box_run";
    Mode = 2'd3;
    while (nframes < 447) frame_start();
    tag = "box_f448";
    frame_start();
    repeat (32) line(1);
    line(480);
    tag = "box_f449";
    frame_start();
    repeat (32) line(1);
    line(480);

    tag = "tail";
    repeat (3) tick(1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
